// File: rtl/event_arbiter.sv
// Event arbiter: edge-detects level event lines, timestamps each new event,
// holds one pending event per line and drains them round-robin into a
// single ready/valid output stage. Repeat events on a still-pending line
// are counted as drops.
module event_arbiter #(
  parameter int unsigned p_n_in  = 8,
  parameter int unsigned p_width = 9
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [p_n_in:1]           i_event,
  input  logic                      i_evt_ready,
  output logic                      o_evt_valid,
  output logic [$clog2(p_n_in)-1:0] o_evt_addr,
  output logic [p_width-1:0]        o_evt_ts,
  output logic [p_n_in:1]           o_pending,
  output logic [7:0]                o_drop_cnt,
  output logic                      o_busy
);

  localparam int unsigned p_aw       = $clog2(p_n_in);
  localparam logic [7:0]  p_drop_max = 8'hFF;

  // State
  logic [p_n_in-1:0]  event_q,   event_d;
  logic [p_width-1:0] ts_cnt_q,  ts_cnt_d;
  logic [p_n_in-1:0]  pending_q, pending_d;
  logic [p_width-1:0] ts_reg_q [p_n_in];
  logic [p_width-1:0] ts_reg_d [p_n_in];
  logic               valid_q,   valid_d;
  logic [p_aw-1:0]    addr_q,    addr_d;
  logic [p_width-1:0] ts_q,      ts_d;
  logic [p_aw-1:0]    ptr_q,     ptr_d;
  logic [7:0]         drop_q,    drop_d;
  logic               busy_q,    busy_d;

  // Combinational helpers
  logic               found_c;
  logic [p_aw-1:0]    sel_c;
  logic               stage_free_c;
  logic               load_c;
  logic [p_n_in-1:0]  load_vec_c;
  logic [p_n_in-1:0]  rise_c;
  logic [p_n_in-1:0]  set_vec_c;
  logic [p_n_in-1:0]  drop_vec_c;

  // Round-robin search: first pending line starting just after the last grant
  always_comb begin
    found_c = 1'b0;
    sel_c   = '0;
    for (int unsigned off = 1; off <= p_n_in; off++) begin
      if (!found_c && pending_q[p_aw'((32'(ptr_q) + off) % p_n_in)]) begin
        found_c = 1'b1;
        sel_c   = p_aw'((32'(ptr_q) + off) % p_n_in);
      end
    end
  end

  // Edge detect, load decision and capture/drop classification
  always_comb begin
    stage_free_c = !valid_q || i_evt_ready;
    load_c       = stage_free_c && found_c;
    load_vec_c   = load_c ? (p_n_in'(1) << sel_c) : '0;
    rise_c       = i_event & ~event_q;
    // A line being unloaded this edge may accept a fresh capture
    set_vec_c    = rise_c & (~pending_q | load_vec_c);
    drop_vec_c   = rise_c & pending_q & ~load_vec_c;
  end

  // Next-state computation
  always_comb begin
    event_d   = i_event;
    ts_cnt_d  = ts_cnt_q + p_width'(1);
    pending_d = (pending_q & ~load_vec_c) | set_vec_c;
    ts_reg_d  = ts_reg_q;
    drop_d    = drop_q;
    valid_d   = valid_q;
    addr_d    = addr_q;
    ts_d      = ts_q;
    ptr_d     = ptr_q;

    for (int unsigned k = 0; k < p_n_in; k++) begin
      if (set_vec_c[p_aw'(k)]) begin
        ts_reg_d[p_aw'(k)] = ts_cnt_q;
      end
    end

    // Any number of drops in one cycle counts once
    if ((|drop_vec_c) && (drop_q != p_drop_max)) begin
      drop_d = drop_q + 8'd1;
    end

    if (stage_free_c) begin
      valid_d = found_c;
      if (found_c) begin
        addr_d = sel_c;
        ts_d   = ts_reg_q[sel_c];
        ptr_d  = sel_c;
      end
    end

    busy_d = valid_d | (|pending_d);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      event_q   <= '1;
      ts_cnt_q  <= '0;
      pending_q <= '0;
      ts_reg_q  <= '{default: '0};
      valid_q   <= 1'b0;
      addr_q    <= '0;
      ts_q      <= '0;
      ptr_q     <= p_aw'(p_n_in - 1);
      drop_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      event_q   <= event_d;
      ts_cnt_q  <= ts_cnt_d;
      pending_q <= pending_d;
      ts_reg_q  <= ts_reg_d;
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      ts_q      <= ts_d;
      ptr_q     <= ptr_d;
      drop_q    <= drop_d;
      busy_q    <= busy_d;
    end
  end

  assign o_evt_valid = valid_q;
  assign o_evt_addr  = addr_q;
  assign o_evt_ts    = ts_q;
  assign o_pending   = pending_q;
  assign o_drop_cnt  = drop_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_event_arbiter.sv
// Self-checking bench for event_arbiter: scoreboard of expected output
// events (address, timestamp) filled when stimulus is driven.
module tb_event_arbiter;

  localparam int unsigned N      = 8;
  localparam int unsigned W      = 9;
  localparam int unsigned AW     = 3;
  localparam int unsigned TS_MOD = 512;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [N:1]    i_event;
  logic          i_evt_ready;
  logic          o_evt_valid;
  logic [AW-1:0] o_evt_addr;
  logic [W-1:0]  o_evt_ts;
  logic [N:1]    o_pending;
  logic [7:0]    o_drop_cnt;
  logic          o_busy;

  event_arbiter #(.p_n_in(N), .p_width(W)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_event     (i_event),
    .i_evt_ready (i_evt_ready),
    .o_evt_valid (o_evt_valid),
    .o_evt_addr  (o_evt_addr),
    .o_evt_ts    (o_evt_ts),
    .o_pending   (o_pending),
    .o_drop_cnt  (o_drop_cnt),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int unsigned addr;
    int unsigned ts;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;   // edges since the last reset edge
  bit          sb_en   = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected event for line address a, captured on the coming edge
  task automatic push(input int unsigned a);
    exp_t e;
    e.addr = a;
    e.ts   = cyc % TS_MOD;
    sb_q.push_back(e);
  endtask

  // One clock: score a handshake about to complete, then advance
  task automatic step();
    exp_t e;
    if (sb_en && i_evt_ready && o_evt_valid) begin
      if (sb_q.size() == 0) begin
        chk("spurious_evt", 32'(o_evt_valid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_addr", 32'(o_evt_addr), e.addr);
        chk("sb_ts",   32'(o_evt_ts),   e.ts);
      end
    end
    @(posedge i_clk);
    if (!i_rst_n) cyc = 0;
    else          cyc++;
    #1;
  endtask

  task automatic drain();
    int k = 0;
    while (sb_q.size() > 0 && k < 200) begin
      step();
      k++;
    end
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    bit save = sb_en;
    sb_en = 1'b0;
    sb_q.delete();
    i_rst_n = 1'b0;
    step();
    step();
    i_rst_n = 1'b1;
    sb_en = save;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned exp_next;
    int unsigned grants;

    i_rst_n     = 1'b0;
    i_event     = '0;
    i_evt_ready = 1'b1;
    do_reset();

    // Reset state
    chk("rst_valid",   32'(o_evt_valid), 32'd0);
    chk("rst_addr",    32'(o_evt_addr),  32'd0);
    chk("rst_ts",      32'(o_evt_ts),    32'd0);
    chk("rst_pending", 32'(o_pending),   32'd0);
    chk("rst_drop",    32'(o_drop_cnt),  32'd0);
    chk("rst_busy",    32'(o_busy),      32'd0);

    // Line 1 held three cycles: one event, valid after the second edge
    step();
    step();
    i_event = 8'h01;
    push(0);
    step();
    chk("lat_e1_valid", 32'(o_evt_valid), 32'd0);
    chk("lat_e1_pend",  32'(o_pending),   32'h01);
    step();
    chk("lat_e2_valid", 32'(o_evt_valid), 32'd1);
    chk("lat_e2_addr",  32'(o_evt_addr),  32'd0);
    step();
    chk("one_pulse", 32'(o_evt_valid), 32'd0);
    i_event = 8'h00;
    drain();
    repeat (5) step();

    // Lines 1 and 8 together: addr 0 then 7, same timestamp
    do_reset();
    step();
    i_event = 8'h81;
    push(0);
    push(7);
    step();
    i_event = 8'h00;
    step();
    chk("pair_v0",   32'(o_evt_valid), 32'd1);
    chk("pair_a0",   32'(o_evt_addr),  32'd0);
    step();
    chk("pair_v1",   32'(o_evt_valid), 32'd1);
    chk("pair_a1",   32'(o_evt_addr),  32'd7);
    step();
    chk("pair_done", 32'(o_evt_valid), 32'd0);
    drain();

    // Backpressure: line 1, then line 3 twice (second one drops)
    i_evt_ready = 1'b0;
    i_event = 8'h01; push(0); step();
    i_event = 8'h00; step();
    chk("bp_stall_valid", 32'(o_evt_valid), 32'd1);
    i_event = 8'h04; push(2); step();
    i_event = 8'h00; step();
    i_event = 8'h04; step();
    i_event = 8'h00; step();
    step();
    chk("bp_drop",    32'(o_drop_cnt),  32'd1);
    chk("bp_pending", 32'(o_pending),   32'h04);
    chk("bp_addr",    32'(o_evt_addr),  32'd0);
    chk("bp_busy",    32'(o_busy),      32'd1);
    i_evt_ready = 1'b1;
    drain();
    chk("bp_idle_pend", 32'(o_pending), 32'd0);
    chk("bp_idle_busy", 32'(o_busy),    32'd0);

    // Reset mid-transfer with valid=1 and pending=F0; a line held through reset
    i_evt_ready = 1'b0;
    i_event = 8'h01; push(0); step();
    i_event = 8'hF0; step();
    i_event = 8'h00; step();
    chk("mid_valid",   32'(o_evt_valid), 32'd1);
    chk("mid_pending", 32'(o_pending),   32'hF0);
    sb_q.delete();
    i_rst_n = 1'b0;
    i_event = 8'h02;
    step();
    i_rst_n = 1'b1;
    chk("mr_valid",   32'(o_evt_valid), 32'd0);
    chk("mr_pending", 32'(o_pending),   32'd0);
    chk("mr_drop",    32'(o_drop_cnt),  32'd0);
    chk("mr_busy",    32'(o_busy),      32'd0);
    i_evt_ready = 1'b1;
    repeat (5) step();
    chk("held_no_pend",  32'(o_pending),   32'd0);
    chk("held_no_valid", 32'(o_evt_valid), 32'd0);
    i_event = 8'h00;
    step();

    // All lines re-pulsed continuously: strict rotation 0..7,0..
    sb_en    = 1'b0;
    exp_next = 0;
    grants   = 0;
    for (int c = 0; c < 40; c++) begin
      i_event = (c % 2 == 0) ? 8'hFF : 8'h00;
      step();
      if (o_evt_valid) begin
        chk("rr_order", 32'(o_evt_addr), exp_next);
        exp_next = (exp_next + 1) % N;
        grants++;
      end
      if (grants > 0) chk("rr_busy", 32'(o_busy), 32'd1);
    end
    chk("rr_grants", grants, 32'd39);
    i_event = 8'h00;
    do_reset();
    sb_en = 1'b1;

    // Timestamp wrap: 600 idle cycles, then one event
    repeat (600) step();
    i_event = 8'h01; push(0); step();
    i_event = 8'h00;
    drain();

    // Drop counter saturation
    i_evt_ready = 1'b0;
    i_event = 8'h01; push(0); step();
    i_event = 8'h00; step();
    i_event = 8'h02; push(1); step();
    i_event = 8'h00; step();
    for (int p = 1; p <= 300; p++) begin
      i_event = 8'h02; step();
      i_event = 8'h00; step();
      if (p == 10)  chk("drop_10",  32'(o_drop_cnt), 32'd10);
      if (p == 255) chk("drop_255", 32'(o_drop_cnt), 32'd255);
    end
    chk("drop_sat",     32'(o_drop_cnt), 32'd255);
    chk("drop_pending", 32'(o_pending),  32'h02);
    i_evt_ready = 1'b1;
    drain();
    repeat (4) step();
    chk("end_busy", 32'(o_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/event_arbiter.md
EVENT_ARBITER -- requirements
Module: event_arbiter

Interface
REQ-001 SHALL have parameter p_n_in, default 8: number of input event lines.
REQ-002 SHALL have parameter p_width, default 9: timestamp width in bits.
REQ-003 SHALL have port i_clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port i_event, input, [p_n_in:1]: level event lines; bit k maps to address k-1.
REQ-006 SHALL have port i_evt_ready, input, 1 bit: downstream layer-1 accepts the event.
REQ-007 SHALL have port o_evt_valid, output, 1 bit: output event present.
REQ-008 SHALL have port o_evt_addr, output, $clog2(p_n_in) bits: source line index, 0-based.
REQ-009 SHALL have port o_evt_ts, output, p_width bits: capture timestamp of the event.
REQ-010 SHALL have port o_pending, output, [p_n_in:1]: captured events not yet loaded to output.
REQ-011 SHALL have port o_drop_cnt, output, 8 bits: saturating count of dropped events.
REQ-012 SHALL have port o_busy, output, 1 bit: o_evt_valid OR (|o_pending).

Function
REQ-013 SHALL register i_event each cycle into r_event_d; rise[k] = i_event[k] AND NOT r_event_d[k].
REQ-014 SHALL treat a line held high for many cycles as exactly one event.
REQ-015 SHALL run a free-running p_width-bit timestamp counter, +1 per cycle, wrapping 2^p_width-1 -> 0.
REQ-016 SHALL, on rise[k] with pending[k]=0 (or pending[k] being loaded this cycle), set pending[k] and store the current counter value in ts_reg[k].
REQ-017 SHALL, on rise[k] with pending[k]=1 and not loaded this cycle, keep the original ts_reg[k] and increment o_drop_cnt, saturating at 255.
REQ-018 SHALL count multiple simultaneous drops in one cycle as one increment.
REQ-019 SHALL treat the output stage as free when o_evt_valid=0 or (o_evt_valid AND i_evt_ready).
REQ-020 SHALL, when the output stage is free and pending is non-zero, select the first set pending bit searching round-robin from index ptr+1 upward with wrap.
REQ-021 SHALL load the selected index and its ts_reg into o_evt_addr/o_evt_ts, assert o_evt_valid, clear that pending bit, and set ptr to that index, all on one edge.
REQ-022 SHALL deassert o_evt_valid when the output stage is free and pending is zero.
REQ-023 SHALL hold o_evt_valid, o_evt_addr and o_evt_ts stable while o_evt_valid=1 and i_evt_ready=0.
REQ-024 SHALL give a latency of 2 cycles from the first edge sampling i_event[k] high to o_evt_valid high, when the output stage is free and no other events are pending.
REQ-025 SHALL sustain 1 event per cycle throughput with i_evt_ready held high.
REQ-026 SHALL allow the rise on line k and the load of pending[k] in the same cycle; the new event stays pending with the new timestamp, with no drop.

Reset
REQ-027 SHALL, while i_rst_n=0 at a clock edge, clear o_evt_valid, o_evt_addr, o_evt_ts, pending, all ts_reg, o_drop_cnt and the timestamp counter to 0.
REQ-028 SHALL, while in reset, set ptr to p_n_in-1 so that index 0 wins first after reset.
REQ-029 SHALL, while in reset, set r_event_d to all ones, so a line already high at reset release produces no event.
REQ-030 SHALL apply reset mid-transfer with no handshake completion; the in-flight event is discarded.

Verification
REQ-031 SHALL cover: i_event=8'h01 held 3 cycles, ready=1 -> exactly one o_evt_valid pulse, addr=0, ts=capture cycle, valid 2 cycles after first high sample.
REQ-032 SHALL cover: i_event=8'h81 in one cycle, ready=1 -> addr 0 then addr 7 on consecutive cycles, identical ts.
REQ-033 SHALL cover: ready=0; pulse line 1, then pulse line 3 twice -> o_drop_cnt=1, o_pending=8'h04; then ready=1 -> addr 0, then addr 2 with first-pulse ts.
REQ-034 SHALL cover: all lines re-pulsed continuously, ready=1 -> grant order 0,1,...,7,0 with no line starved; o_busy stays 1.
REQ-035 SHALL cover: reset held one cycle with valid=1 and pending=8'hF0 -> next cycle valid=0, pending=0, drop_cnt=0; a line held high through reset yields no event.
REQ-036 SHALL cover: 600 idle cycles then one pulse -> ts equals cycle count mod 512; 300 forced drops -> o_drop_cnt=255.
